cl_digit_serial_mult: RTL and testbench
=======================================

CL_DIGIT_SERIAL_MULT -- requirements
Module: cl_digit_serial_mult

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width N in bits.
REQ-002 SHALL have parameter DIGIT_WIDTH, default 4, multiplier bits D consumed per compute cycle; legal values divide DATA_WIDTH, 1 <= D <= N.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port enable  input  1  reset: synchronous, active-low; enable=0 at a rising clk edge resets the block.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port in_mult_a  input  N  multiplicand polynomial, bit i = coefficient of x^i.
REQ-008 SHALL have port in_mult_b  input  N  multiplier polynomial.
REQ-009 SHALL have port in_poly  input  N  low terms of reduction polynomial x^N + in_poly.
REQ-010 SHALL have port in_reduce  input  1  mode: 0 = full carry-less product, 1 = product mod (x^N + in_poly).
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port out_mult_result  output  2N  result; upper N bits 0 in reduce mode.

Function
REQ-014 SHALL implement states IDLE, CALC, DONE; ITER = N/D.
REQ-015 in IDLE SHALL drive in_ready=1, out_valid=0.
REQ-016 transfer occurs when in_valid=1 and in_ready=1 at an edge; SHALL latch a, b, poly, reduce, clear accumulator, clear iteration counter, go to CALC.
REQ-017 operands SHALL be sampled only at the transfer edge; input changes afterwards SHALL not affect the result.
REQ-018 in CALC SHALL drive in_ready=0, out_valid=0; in_valid ignored.
REQ-019 each CALC cycle SHALL process the next D bits of b, MSB digit first (Horner): per bit, acc = (acc << 1) XOR (bit ? a : 0), bit order MSB to LSB within the digit.
REQ-020 in reduce mode, after each 1-bit shift, if acc bit N is set SHALL clear it and XOR in_poly into acc[N-1:0], keeping acc degree < N.
REQ-021 in full mode SHALL perform no reduction; acc is 2N bits, bit 2N-1 always 0.
REQ-022 after the ITER-th CALC cycle SHALL go to DONE; out_valid SHALL rise exactly ITER cycles after the transfer edge.
REQ-023 in DONE SHALL drive out_valid=1, in_ready=0; out_mult_result SHALL equal acc and hold stable while out_ready=0.
REQ-024 on out_valid=1 and out_ready=1 at an edge SHALL return to IDLE; a new transfer is possible from the following cycle (no same-cycle accept in DONE).
REQ-025 out_mult_result SHALL retain its last value in IDLE and CALC until overwritten by the next completion.
REQ-026 D=N SHALL give ITER=1; D=1 SHALL give ITER=N.
REQ-027 in_poly=0 in reduce mode SHALL yield product mod x^N (truncation to low N bits).

Reset
REQ-028 enable=0 at an edge SHALL force IDLE, counter=0, accumulator=0, out_mult_result=0, out_valid=0; in_ready=1 from the next cycle.
REQ-029 reset SHALL take priority over transfer and handshake in the same cycle, and mid-CALC or in DONE SHALL abandon the operation with no out_valid.

Verification
REQ-030 N=8, D=2, full: a=0x53, b=0xCA -> out_valid 4 cycles after transfer, result 0x3F7E.
REQ-031 N=8, D=2, reduce, poly=0x1B: a=0x53, b=0xCA -> result 0x0001; a=0xFF, b=0xFF full -> 0x5555.
REQ-032 N=8, D=8 and D=1: a=0x53, b=0xCA full -> 0x3F7E after 1 and 8 cycles respectively; b=0 -> 0x0000.
REQ-033 hold out_ready=0 five cycles in DONE, toggle in_valid and inputs -> result, out_valid stable, in_ready=0, no new accept.
REQ-034 enable=0 on the 2nd CALC cycle -> out_valid never asserts, out_mult_result=0, in_ready=1 next cycle; fresh transfer completes correctly.
REQ-035 back-to-back: in_valid held high with two operand sets, out_ready=1 -> two results in order, one idle cycle between DONE and next accept.

Source files
------------

// File: rtl/cl_digit_serial_mult.sv
// cl_digit_serial_mult: digit-serial carry-less multiplier with optional modular reduction
module cl_digit_serial_mult #(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_mult_a,
  input  logic [DATA_WIDTH-1:0]   in_mult_b,
  input  logic [DATA_WIDTH-1:0]   in_poly,
  input  logic                    in_reduce,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_mult_result
);
  localparam int N    = DATA_WIDTH;
  localparam int D    = DIGIT_WIDTH;
  localparam int ITER = N / D;
  localparam int CW   = ITER > 1 ? $clog2(ITER) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d, poly_q, poly_d;
  logic            red_q, red_d;
  logic [2*N-1:0]  acc_q, acc_d, res_q, res_d, step;
  logic            last;
  assign last            = cnt_q == CW'(ITER - 1);
  assign out_mult_result = res_q;
  // Horner step over the top digit of b: shift, fold bit N back in reduce mode, add a
  always_comb begin
    step = acc_q;
    for (int j = D - 1; j >= 0; j--) begin
      step = {step[2*N-2:0], 1'b0};
      step = (red_q && step[N]) ? step ^ {{(N-1){1'b0}}, 1'b1, poly_q} : step;
      step = b_q[N-D+j] ? step ^ {{N{1'b0}}, a_q} : step;
    end
  end
  // next-state, datapath updates and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    poly_d    = poly_q;
    red_d     = red_q;
    acc_d     = acc_q;
    res_d     = res_q;
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    if (state_q == IDLE && in_valid) begin
      a_d     = in_mult_a;
      b_d     = in_mult_b;
      poly_d  = in_poly;
      red_d   = in_reduce;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = CALC;
    end
    if (state_q == CALC) begin
      acc_d   = step;
      b_d     = b_q << D;
      cnt_d   = cnt_q + 1'b1;
      state_d = last ? DONE : CALC;
      res_d   = last ? step : res_q;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  // state register with synchronous active-low reset on enable
  always_ff @(posedge clk) begin
    if (!enable) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      poly_q  <= '0;
      red_q   <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      poly_q  <= poly_d;
      red_q   <= red_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_cl_digit_serial_mult.sv
// tb_cl_digit_serial_mult: random and directed checks of three digit widths against a polynomial model
module tb_cl_digit_serial_mult;
  logic clk = 0, enable = 0, in_valid = 0, in_reduce = 0, out_ready = 1;
  logic [7:0] in_mult_a = 0, in_mult_b = 0, in_poly = 0;
  logic ir2, ov2, ir8, ov8, ir1, ov1;
  logic [15:0] res2, res8, res1, last2;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  cl_digit_serial_mult #(.DATA_WIDTH(8), .DIGIT_WIDTH(2)) dut2 (.clk(clk), .enable(enable), .in_valid(in_valid),
    .in_ready(ir2), .in_mult_a(in_mult_a), .in_mult_b(in_mult_b), .in_poly(in_poly), .in_reduce(in_reduce),
    .out_valid(ov2), .out_ready(out_ready), .out_mult_result(res2));
  cl_digit_serial_mult #(.DATA_WIDTH(8), .DIGIT_WIDTH(8)) dut8 (.clk(clk), .enable(enable), .in_valid(in_valid),
    .in_ready(ir8), .in_mult_a(in_mult_a), .in_mult_b(in_mult_b), .in_poly(in_poly), .in_reduce(in_reduce),
    .out_valid(ov8), .out_ready(out_ready), .out_mult_result(res8));
  cl_digit_serial_mult #(.DATA_WIDTH(8), .DIGIT_WIDTH(1)) dut1 (.clk(clk), .enable(enable), .in_valid(in_valid),
    .in_ready(ir1), .in_mult_a(in_mult_a), .in_mult_b(in_mult_b), .in_poly(in_poly), .in_reduce(in_reduce),
    .out_valid(ov1), .out_ready(out_ready), .out_mult_result(res1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // schoolbook carry-less product, then long division by x^8 + p
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p, input logic r);
    logic [15:0] x;
    x = 0;
    for (int i = 0; i < 8; i++) if (b[i]) x = x ^ ({8'h0, a} << i);
    if (r) for (int k = 14; k >= 8; k--) if (x[k]) x = x ^ ((16'h100 | {8'h0, p}) << (k - 8));
    return x;
  endfunction
  task automatic scramble;
    in_mult_a = 8'($urandom);
    in_mult_b = 8'($urandom);
    in_poly   = 8'($urandom);
    in_reduce = 1'($urandom);
  endtask
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p, input logic r);
    logic [15:0] e, r2, r8, r1;
    int l2, l8, l1;
    e = model(a, b, p, r);
    l2 = -1; l8 = -1; l1 = -1; r2 = 0; r8 = 0; r1 = 0;
    chk("op_ready", {ir2, ir8, ir1}, 3'b111);
    in_mult_a = a; in_mult_b = b; in_poly = p; in_reduce = r;
    in_valid = 1; out_ready = 1;
    tick;
    in_valid = 0;
    scramble;
    for (int c = 1; c <= 12; c++) begin
      tick;
      if (ov2 && l2 < 0) begin l2 = c; r2 = res2; end
      if (ov8 && l8 < 0) begin l8 = c; r8 = res8; end
      if (ov1 && l1 < 0) begin l1 = c; r1 = res1; end
    end
    chk("lat_d2", l2, 4);
    chk("lat_d8", l8, 1);
    chk("lat_d1", l1, 8);
    chk("res_d2", r2, e);
    chk("res_d8", r8, e);
    chk("res_d1", r1, e);
    last2 = r2;
  endtask
  initial begin
    logic [15:0] e, ea, eb, hold, r1v, r2v;
    logic [7:0] a, b, p;
    logic r, saw, irs;
    int c1, c2, n;
    tick; tick;
    chk("rst_ready", {ir2, ir8, ir1}, 3'b111);
    chk("rst_valid", {ov2, ov8, ov1}, 3'b000);
    chk("rst_res", {res2, res8}, 32'h0);
    chk("rst_res1", res1, 16'h0);
    enable = 1;
    tick;
    run_op(8'h53, 8'hCA, 8'h00, 0); chk("kat_full", last2, 16'h3F7E);
    run_op(8'h53, 8'hCA, 8'h1B, 1); chk("kat_aes", last2, 16'h0001);
    run_op(8'hFF, 8'hFF, 8'h1B, 0); chk("kat_ff", last2, 16'h5555);
    run_op(8'h53, 8'h00, 8'h00, 0); chk("kat_zero", last2, 16'h0000);
    run_op(8'hB7, 8'hE9, 8'h00, 1); chk("kat_trunc", last2, {8'h0, model(8'hB7, 8'hE9, 8'h0, 0) & 16'h00FF});
    // stall in DONE while inputs wiggle
    a = 8'($urandom); b = 8'($urandom); p = 8'($urandom); r = 1'($urandom);
    e = model(a, b, p, r);
    in_mult_a = a; in_mult_b = b; in_poly = p; in_reduce = r;
    out_ready = 0; in_valid = 1;
    tick;
    in_valid = 0;
    for (int c = 1; c <= 12 && !ov2; c++) tick;
    chk("stall_valid", ov2, 1);
    chk("stall_res", res2, e);
    hold = res2;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      scramble;
      tick;
      chk("stall_hold_v", ov2, 1);
      chk("stall_hold_r", ir2, 0);
      chk("stall_hold_d", res2, hold);
    end
    in_valid = 0; out_ready = 1;
    tick;
    chk("rel_valid", ov2, 0);
    chk("rel_ready", ir2, 1);
    chk("rel_retain", res2, hold);
    tick;
    // reset during the second compute cycle
    in_mult_a = 8'($urandom); in_mult_b = 8'($urandom) | 8'h80; in_poly = 8'($urandom); in_reduce = 0;
    in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    enable = 0;
    tick;
    enable = 1;
    chk("abort_valid", ov2, 0);
    chk("abort_res", res2, 0);
    chk("abort_ready", ir2, 1);
    saw = 0;
    for (int c = 0; c < 10; c++) begin tick; saw = saw | ov2 | ov1; end
    chk("abort_novalid", saw, 0);
    run_op(8'h53, 8'hCA, 8'h00, 0);
    // back-to-back with in_valid held high
    a = 8'($urandom); b = 8'($urandom); ea = model(a, b, 8'h1B, 1);
    in_mult_a = a; in_mult_b = b; in_poly = 8'h1B; in_reduce = 1;
    in_valid = 1; out_ready = 1;
    tick;
    a = 8'($urandom); b = 8'($urandom); eb = model(a, b, 8'h00, 0);
    in_mult_a = a; in_mult_b = b; in_poly = 8'h00; in_reduce = 0;
    n = 0; c1 = -1; c2 = -1; r1v = 0; r2v = 0; irs = 0;
    for (int c = 1; c <= 16; c++) begin
      tick;
      if (c == 5) irs = ir2;
      if (ov2) begin
        if (n == 0) begin c1 = c; r1v = res2; end
        if (n == 1) begin c2 = c; r2v = res2; in_valid = 0; end
        n++;
      end
    end
    in_valid = 0;
    chk("b2b_count", n, 2);
    chk("b2b_lat1", c1, 4);
    chk("b2b_res1", r1v, ea);
    chk("b2b_idle", irs, 1);
    chk("b2b_lat2", c2, 10);
    chk("b2b_res2", r2v, eb);
    for (int c = 0; c < 12; c++) tick;
    for (int t = 0; t < 30; t++)
      run_op(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
